// File: rtl/k423_if_ibuf.sv
// k423_if_ibuf: in-order instruction fetch buffer between inst mem and decode
//   Optional macro K423_IBUF_BYPASS_EN: forward a response straight to decode when the buffer has no filled entry waiting.
//   Ports:
//     clk_i, rst_i            clock, synchronous active-high reset
//     pcu_flush_br_i          branch flush
//     req_fire_i, req_pc_i    accepted fetch request and its PC
//     mem_rsp_vld_i/rdata_i   in-order inst mem response
//     ibuf_rdy_o              free entry available
//     id_vld_o/rdy_i/pc_o/inst_o  head entry handshake to decode
//     ibuf_cnt_o              allocated entries (filled or pending)
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif
`ifndef CORE_FETCH_W
`define CORE_FETCH_W 32
`endif
module k423_if_ibuf #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = `CORE_ADDR_W,
    parameter int INST_W = `CORE_FETCH_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pcu_flush_br_i,
    input  logic                       req_fire_i,
    input  logic [PC_W-1:0]            req_pc_i,
    input  logic                       mem_rsp_vld_i,
    input  logic [INST_W-1:0]          mem_rsp_rdata_i,
    output logic                       ibuf_rdy_o,
    output logic                       id_vld_o,
    input  logic                       id_rdy_i,
    output logic [PC_W-1:0]            id_pc_o,
    output logic [INST_W-1:0]          id_inst_o,
    output logic [$clog2(DEPTH):0]     ibuf_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [PW-1:0]     r_alloc, r_fill, r_read, r_drop;
    logic [DEPTH-1:0]  r_filled;
    logic [PC_W-1:0]   r_pc   [DEPTH];
    logic [INST_W-1:0] r_inst [DEPTH];
    logic [PW-1:0]     w_cnt, w_drop_nxt;
    logic [AW-1:0]     w_ra, w_fa, w_aa;
    logic              w_rsp_ok, w_head, w_byp, w_pop, w_wr;
    assign w_ra  = r_read[AW-1:0];
    assign w_fa  = r_fill[AW-1:0];
    // a request in the flush cycle belongs to the new stream and lands in entry 0
    assign w_aa  = pcu_flush_br_i ? '0 : r_alloc[AW-1:0];
    assign w_cnt = r_alloc - r_read;
    // responses still owed to pre-flush requests must be swallowed later
    assign w_drop_nxt = r_drop + (r_alloc - r_fill) - {{AW{1'b0}}, mem_rsp_vld_i};
    assign w_rsp_ok = mem_rsp_vld_i && !pcu_flush_br_i && r_drop == '0 && r_fill != r_alloc;
    assign w_head   = !pcu_flush_br_i && r_filled[w_ra] && r_read != r_fill;
`ifdef K423_IBUF_BYPASS_EN
    assign w_byp = w_rsp_ok && r_read == r_fill;
`else
    assign w_byp = 1'b0;
`endif
    assign id_vld_o   = w_head || w_byp;
    assign id_pc_o    = id_vld_o ? r_pc[w_ra] : '0;
    assign id_inst_o  = w_byp ? mem_rsp_rdata_i : (w_head ? r_inst[w_ra] : '0);
    assign w_pop      = id_vld_o && id_rdy_i;
    assign w_wr       = w_rsp_ok && !(w_byp && id_rdy_i);
    assign ibuf_rdy_o = w_cnt < PW'(DEPTH);
    assign ibuf_cnt_o = w_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_alloc  <= '0;
            r_fill   <= '0;
            r_read   <= '0;
            r_drop   <= '0;
            r_filled <= '0;
        end else if (pcu_flush_br_i) begin
            r_alloc  <= {{AW{1'b0}}, req_fire_i};
            r_fill   <= '0;
            r_read   <= '0;
            r_drop   <= w_drop_nxt;
            r_filled <= '0;
        end else begin
            if (mem_rsp_vld_i && r_drop != '0)
                r_drop <= r_drop - PW'(1);
            if (w_rsp_ok)
                r_fill <= r_fill + PW'(1);
            if (w_wr)
                r_filled[w_fa] <= 1'b1;
            if (req_fire_i) begin
                r_filled[w_aa] <= 1'b0;
                r_alloc        <= r_alloc + PW'(1);
            end
            if (w_pop)
                r_read <= r_read + PW'(1);
        end
    end
    always_ff @(posedge clk_i) begin
        if (req_fire_i)
            r_pc[w_aa] <= req_pc_i;
        if (w_wr)
            r_inst[w_fa] <= mem_rsp_rdata_i;
    end
    // a response with nothing outstanding and nothing to drop is a protocol error
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            assert (!(mem_rsp_vld_i && r_drop == '0 && r_fill == r_alloc));
    end
endmodule

// File: tb/tb_k423_if_ibuf.sv
// tb_k423_if_ibuf: directed self-checking bench for k423_if_ibuf (default build)
module tb_k423_if_ibuf;
    logic        clk_i = 1'b0;
    logic        rst_i, pcu_flush_br_i, req_fire_i, mem_rsp_vld_i, id_rdy_i;
    logic [31:0] req_pc_i, mem_rsp_rdata_i, id_pc_o, id_inst_o;
    logic        ibuf_rdy_o, id_vld_o;
    logic [2:0]  ibuf_cnt_o;
    int          total = 0;
    int          bad = 0;
    k423_if_ibuf dut (
        .clk_i(clk_i), .rst_i(rst_i), .pcu_flush_br_i(pcu_flush_br_i),
        .req_fire_i(req_fire_i), .req_pc_i(req_pc_i),
        .mem_rsp_vld_i(mem_rsp_vld_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
        .ibuf_rdy_o(ibuf_rdy_o), .id_vld_o(id_vld_o), .id_rdy_i(id_rdy_i),
        .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .ibuf_cnt_o(ibuf_cnt_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask
    task automatic look();
        #4;
    endtask
    task automatic idle();
        pcu_flush_br_i = 0; req_fire_i = 0; mem_rsp_vld_i = 0;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_vld"}, id_vld_o, 0);
        chk({tag, "_rdy"}, ibuf_rdy_o, 1);
        chk({tag, "_cnt"}, ibuf_cnt_o, 0);
        chk({tag, "_pc"}, id_pc_o, 0);
        chk({tag, "_inst"}, id_inst_o, 0);
    endtask
    initial begin
        int issued, rsp, popped, owed;
        bit prev_stall;
        logic [15:0] pat;
        rst_i = 1; idle(); id_rdy_i = 0; req_pc_i = 0; mem_rsp_rdata_i = 0;
        step(); step();
        rst_i = 0;
        look(); chk_reset("rst");
        // single request then response: visible one cycle after response
        step(); req_fire_i = 1; req_pc_i = 32'h8000_0000; id_rdy_i = 1;
        step(); idle(); mem_rsp_vld_i = 1; mem_rsp_rdata_i = 32'h13;
        look(); chk("s1_vld_early", id_vld_o, 0); chk("s1_cnt", ibuf_cnt_o, 1);
        step(); idle();
        look(); chk("s1_vld", id_vld_o, 1); chk("s1_pc", id_pc_o, 32'h8000_0000); chk("s1_inst", id_inst_o, 32'h13);
        step();
        look(); chk("s1_empty_vld", id_vld_o, 0); chk("s1_empty_cnt", ibuf_cnt_o, 0);
        // fill to full with decode stalled
        id_rdy_i = 0;
        for (int i = 0; i < 4; i++) begin
            step(); req_fire_i = 1; req_pc_i = 32'h100 + 32'(4 * i);
        end
        step(); idle();
        look(); chk("s2_full_rdy", ibuf_rdy_o, 0); chk("s2_full_cnt", ibuf_cnt_o, 4);
        for (int i = 0; i < 4; i++) begin
            step(); mem_rsp_vld_i = 1; mem_rsp_rdata_i = 32'hA0 + 32'(i);
        end
        step(); idle();
        look(); chk("s2_head_vld", id_vld_o, 1); chk("s2_head_pc", id_pc_o, 32'h100); chk("s2_head_inst", id_inst_o, 32'hA0);
        step();
        look(); chk("s2_hold_pc", id_pc_o, 32'h100); chk("s2_hold_inst", id_inst_o, 32'hA0); chk("s2_hold_rdy", ibuf_rdy_o, 0);
        id_rdy_i = 1;
        step(); id_rdy_i = 0;
        look(); chk("s2_pop_rdy", ibuf_rdy_o, 1); chk("s2_pop_cnt", ibuf_cnt_o, 3); chk("s2_next_pc", id_pc_o, 32'h104); chk("s2_next_inst", id_inst_o, 32'hA1);
        id_rdy_i = 1;
        step(); step(); step(); id_rdy_i = 0;
        look(); chk("s2_drain_cnt", ibuf_cnt_o, 0); chk("s2_drain_vld", id_vld_o, 0);
        // two outstanding, flush with a new request: two responses dropped
        step(); req_fire_i = 1; req_pc_i = 32'h200;
        step(); req_pc_i = 32'h204;
        step(); pcu_flush_br_i = 1; req_pc_i = 32'h8000_0100;
        look(); chk("s3_flush_vld", id_vld_o, 0);
        step(); idle(); mem_rsp_vld_i = 1; mem_rsp_rdata_i = 32'hD0;
        look(); chk("s3_post_cnt", ibuf_cnt_o, 1); chk("s3_drop_cnt", dut.r_drop, 2); chk("s3_drop0_vld", id_vld_o, 0);
        step(); mem_rsp_rdata_i = 32'hD1;
        look(); chk("s3_drop1_vld", id_vld_o, 0);
        step(); mem_rsp_rdata_i = 32'hE0;
        look(); chk("s3_fill_vld", id_vld_o, 0);
        step(); idle(); id_rdy_i = 1;
        look(); chk("s3_vld", id_vld_o, 1); chk("s3_pc", id_pc_o, 32'h8000_0100); chk("s3_inst", id_inst_o, 32'hE0);
        step(); id_rdy_i = 0;
        look(); chk("s3_done_cnt", ibuf_cnt_o, 0);
        // flush together with a response, three outstanding
        for (int i = 0; i < 3; i++) begin
            step(); req_fire_i = 1; req_pc_i = 32'h300 + 32'(4 * i);
        end
        step(); idle(); pcu_flush_br_i = 1; mem_rsp_vld_i = 1; mem_rsp_rdata_i = 32'hBAD0; id_rdy_i = 1;
        look(); chk("s4_flush_vld", id_vld_o, 0);
        step(); idle(); mem_rsp_vld_i = 1; mem_rsp_rdata_i = 32'hBAD1;
        look(); chk("s4_drop_cnt", dut.r_drop, 2); chk("s4_cnt", ibuf_cnt_o, 0); chk("s4_stale1", id_vld_o, 0);
        step(); mem_rsp_rdata_i = 32'hBAD2;
        look(); chk("s4_stale2", id_vld_o, 0);
        step(); idle(); req_fire_i = 1; req_pc_i = 32'h400;
        look(); chk("s4_stale3", id_vld_o, 0); chk("s4_drop_zero", dut.r_drop, 0);
        step(); idle(); mem_rsp_vld_i = 1; mem_rsp_rdata_i = 32'h44;
        step(); idle();
        look(); chk("s4_new_vld", id_vld_o, 1); chk("s4_new_pc", id_pc_o, 32'h400); chk("s4_new_inst", id_inst_o, 32'h44);
        step();
        // six-entry stream with stalls; pointers wrap
        issued = 0; rsp = 0; popped = 0; prev_stall = 0;
        pat = 16'b1010_0110_0011_1001;
        for (int c = 0; c < 40; c++) begin
            owed = issued - rsp;
            req_fire_i = issued < 6 && ibuf_rdy_o;
            req_pc_i = 32'h500 + 32'(4 * issued);
            mem_rsp_vld_i = owed > 0;
            mem_rsp_rdata_i = 32'h5500 + 32'(rsp);
            id_rdy_i = pat[c % 16];
            look();
            if (prev_stall) chk("s5_hold_vld", id_vld_o, 1);
            if (id_vld_o) begin
                chk("s5_pc", id_pc_o, 32'h500 + 32'(4 * popped));
                chk("s5_inst", id_inst_o, 32'h5500 + 32'(popped));
                if (id_rdy_i) popped++;
            end
            prev_stall = id_vld_o && !id_rdy_i;
            if (req_fire_i) issued++;
            if (mem_rsp_vld_i) rsp++;
            step();
        end
        idle(); id_rdy_i = 0;
        chk("s5_popped", popped, 6);
        look(); chk("s5_end_cnt", ibuf_cnt_o, 0);
        // reset with three entries filled
        for (int i = 0; i < 3; i++) begin
            step(); req_fire_i = 1; req_pc_i = 32'h600 + 32'(4 * i);
        end
        for (int i = 0; i < 3; i++) begin
            step(); idle(); mem_rsp_vld_i = 1; mem_rsp_rdata_i = 32'h66 + 32'(i);
        end
        step(); idle();
        look(); chk("s6_pre_cnt", ibuf_cnt_o, 3); chk("s6_pre_vld", id_vld_o, 1); chk("s6_pre_pc", id_pc_o, 32'h600);
        step(); rst_i = 1;
        step(); rst_i = 0;
        look(); chk_reset("s6_rst");
        step(); step();
        look(); chk_reset("s6_later");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
